trace_buffer_pp: RTL and testbench

Double-buffered (ping-pong) column trace store for the raycaster. The tracer writes one frame's worth of per-column hit records into the back bank while the row renderer reads the front bank; banks swap only at a frame boundary and only once the tracer has committed a complete frame. This replaces the single-bank, bidirectional-port store with separate registered read/write ports and parametrised record widths.

---
 rtl/trace_buffer_pp_if.sv | 43 ++++
 rtl/trace_buffer_pp.sv | 104 ++++++++++
 tb/tb_trace_buffer_pp.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/trace_buffer_pp_if.sv
// Ping-pong trace store port bundle: tracer write side, renderer read side, bank status.
// Latency: none, wires only.
// Backpressure: the tracer must honour wr_ready; writes while it is low are dropped.
interface trace_buffer_pp_if #(
    parameter int COL_W   = 10,
    parameter int VDIST_W = 16,
    parameter int WTID_W  = 2,
    parameter int TEX_W   = 6
);
    logic               wr_en;
    logic [COL_W-1:0]   wr_column;
    logic [VDIST_W-1:0] wr_vdist;
    logic [WTID_W-1:0]  wr_wtid;
    logic               wr_side;
    logic [TEX_W-1:0]   wr_tex;
    logic               wr_commit;
    logic               wr_ready;
    logic               swap;
    logic               rd_en;
    logic [COL_W-1:0]   rd_column;
    logic [VDIST_W-1:0] rd_vdist;
    logic [WTID_W-1:0]  rd_wtid;
    logic               rd_side;
    logic [TEX_W-1:0]   rd_tex;
    logic               rd_valid;
    logic               front_sel;
    logic               front_valid;
    logic               err;

    modport master (
        output wr_en, wr_column, wr_vdist, wr_wtid, wr_side, wr_tex, wr_commit, swap,
        output rd_en, rd_column,
        input  wr_ready, rd_vdist, rd_wtid, rd_side, rd_tex, rd_valid,
        input  front_sel, front_valid, err
    );

    modport slave (
        input  wr_en, wr_column, wr_vdist, wr_wtid, wr_side, wr_tex, wr_commit, swap,
        input  rd_en, rd_column,
        output wr_ready, rd_vdist, rd_wtid, rd_side, rd_tex, rd_valid,
        output front_sel, front_valid, err
    );
endinterface

// File: rtl/trace_buffer_pp.sv
// Double-buffered per-column trace store; banks swap at a frame strobe once the frame is committed.
// Latency: 1-cycle registered reads; a write becomes readable the cycle after commit + swap.
// Backpressure: wr_ready drops from commit until swap; writes in that window are dropped and flag err.
module trace_buffer_pp #(
    parameter int DEPTH   = 640,
    parameter int COL_W   = 10,
    parameter int VDIST_W = 16,
    parameter int WTID_W  = 2,
    parameter int TEX_W   = 6
) (
    input logic              clk,
    input logic              reset_n,
    trace_buffer_pp_if.slave bus
);
    localparam int REC_W = VDIST_W + WTID_W + 1 + TEX_W;
    // DEPTH == 2^COL_W would truncate the bound to zero, so every address is in range then.
    localparam bit              FULL_RANGE = (DEPTH == (1 << COL_W));
    localparam logic [COL_W-1:0] DEPTH_C   = COL_W'(DEPTH);

    typedef enum logic {FILLING = 1'b0, PENDING = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             front_sel_q, front_sel_d;
    logic             front_valid_q, front_valid_d;
    logic             err_q, err_d;
    logic             wr_accept;
    logic             wr_in_range, rd_in_range;
    logic [REC_W-1:0] mem [2][DEPTH];
    logic [REC_W-1:0] rd_q;
    logic             rd_valid_q;

    assign wr_in_range = FULL_RANGE || (bus.wr_column < DEPTH_C);
    assign rd_in_range = FULL_RANGE || (bus.rd_column < DEPTH_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FILLING;
            front_sel_q   <= 1'b0;
            front_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            front_sel_q   <= front_sel_d;
            front_valid_q <= front_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        front_sel_d   = front_sel_q;
        front_valid_d = front_valid_q;
        err_d         = err_q;
        wr_accept     = 1'b0;
        case (state_q)
            FILLING: begin
                wr_accept = bus.wr_en && wr_in_range;
                if (bus.wr_en && !wr_in_range) err_d = 1'b1;
                // Commit with swap in the same cycle flips banks without ever blocking the tracer.
                if (bus.wr_commit) begin
                    if (bus.swap) begin
                        front_sel_d   = ~front_sel_q;
                        front_valid_d = 1'b1;
                    end else begin
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (bus.wr_en) err_d = 1'b1;
                if (bus.swap) begin
                    front_sel_d   = ~front_sel_q;
                    front_valid_d = 1'b1;
                    state_d       = FILLING;
                end
            end
            default: state_d = FILLING;
        endcase
    end

    // Storage is deliberately not reset; front_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[~front_sel_q][bus.wr_column] <= {bus.wr_vdist, bus.wr_wtid, bus.wr_side, bus.wr_tex};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en)
                rd_q <= (rd_in_range && front_valid_q) ? mem[front_sel_q][bus.rd_column] : '0;
        end
    end

    assign {bus.rd_vdist, bus.rd_wtid, bus.rd_side, bus.rd_tex} = rd_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.wr_ready    = (state_q == FILLING);
    assign bus.front_sel   = front_sel_q;
    assign bus.front_valid = front_valid_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_trace_buffer_pp.sv
// Directed bench for trace_buffer_pp: bank swap rules, commit backpressure, range errors, reset.
module tb_trace_buffer_pp;
    localparam int DEPTH   = 640;
    localparam int COL_W   = 10;
    localparam int VDIST_W = 16;
    localparam int WTID_W  = 2;
    localparam int TEX_W   = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    trace_buffer_pp_if #(.COL_W(COL_W), .VDIST_W(VDIST_W), .WTID_W(WTID_W), .TEX_W(TEX_W)) bus ();

    trace_buffer_pp #(
        .DEPTH(DEPTH), .COL_W(COL_W), .VDIST_W(VDIST_W), .WTID_W(WTID_W), .TEX_W(TEX_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en = 1'b0; bus.wr_column = '0; bus.wr_vdist = '0; bus.wr_wtid = '0;
        bus.wr_side = 1'b0; bus.wr_tex = '0; bus.wr_commit = 1'b0; bus.swap = 1'b0;
        bus.rd_en = 1'b0; bus.rd_column = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int col, input int v, input int w, input int s, input int t);
        bus.wr_en = 1'b1; bus.wr_column = COL_W'(col); bus.wr_vdist = VDIST_W'(v);
        bus.wr_wtid = WTID_W'(w); bus.wr_side = s[0]; bus.wr_tex = TEX_W'(t);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input int col);
        bus.rd_en = 1'b1; bus.rd_column = COL_W'(col);
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input int v, input int w, input int s, input int t);
        chk({tag, ".valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, ".vdist"}, 32'(bus.rd_vdist), v);
        chk({tag, ".wtid"},  32'(bus.rd_wtid),  w);
        chk({tag, ".side"},  32'(bus.rd_side),  s);
        chk({tag, ".tex"},   32'(bus.rd_tex),   t);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".wr_ready"},    32'(bus.wr_ready),    32'd1);
        chk({tag, ".front_sel"},   32'(bus.front_sel),   32'd0);
        chk({tag, ".front_valid"}, 32'(bus.front_valid), 32'd0);
        chk({tag, ".err"},         32'(bus.err),         32'd0);
        chk({tag, ".rd_valid"},    32'(bus.rd_valid),    32'd0);
        chk({tag, ".rd_vdist"},    32'(bus.rd_vdist),    32'd0);
        chk({tag, ".rd_wtid"},     32'(bus.rd_wtid),     32'd0);
        chk({tag, ".rd_side"},     32'(bus.rd_side),     32'd0);
        chk({tag, ".rd_tex"},      32'(bus.rd_tex),      32'd0);
    endtask

    initial begin
        idle();
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Read before any frame is committed: valid strobe but zero data.
        rd(5);
        chk_rd("rd_empty", 0, 0, 0, 0);
        chk("rd_empty.front_valid", 32'(bus.front_valid), 32'd0);

        // Frame A: full frame into bank 1.
        for (int c = 0; c < DEPTH; c++) begin
            bus.wr_en = 1'b1; bus.wr_column = COL_W'(c); bus.wr_vdist = VDIST_W'(c);
            bus.wr_wtid = c[1:0]; bus.wr_side = c[0]; bus.wr_tex = c[5:0];
            step();
        end
        bus.wr_en = 1'b0;
        chk("frameA.err", 32'(bus.err), 32'd0);
        bus.wr_commit = 1'b1; step(); bus.wr_commit = 1'b0;
        chk("frameA.commit.wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("frameA.commit.front_sel", 32'(bus.front_sel), 32'd0);
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        chk("frameA.swap.front_sel", 32'(bus.front_sel), 32'd1);
        chk("frameA.swap.front_valid", 32'(bus.front_valid), 32'd1);
        chk("frameA.swap.wr_ready", 32'(bus.wr_ready), 32'd1);
        rd(300);
        chk_rd("rdA300", 300, 0, 0, 44);
        rd(639);
        chk_rd("rdA639", 639, 3, 1, 63);
        step();
        chk("hold.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("hold.rd_vdist", 32'(bus.rd_vdist), 32'd639);

        // Frame B into bank 0, then a write while pending.
        wr(3, 'h333, 1, 1, 7);
        wr(300, 'h777, 2, 0, 5);
        bus.wr_commit = 1'b1; step(); bus.wr_commit = 1'b0;
        chk("pend.wr_ready", 32'(bus.wr_ready), 32'd0);
        wr(3, 'hBAD, 0, 0, 0);
        chk("pend.err", 32'(bus.err), 32'd1);
        chk("pend.wr_ready2", 32'(bus.wr_ready), 32'd0);
        rd(3);
        chk_rd("pend.rd3", 3, 3, 1, 3);
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        chk("frameB.front_sel", 32'(bus.front_sel), 32'd0);
        chk("frameB.wr_ready", 32'(bus.wr_ready), 32'd1);
        rd(3);
        chk_rd("rdB3", 'h333, 1, 1, 7);
        rd(300);
        chk_rd("rdB300", 'h777, 2, 0, 5);

        // Swap without commit is ignored.
        wr(3, 'h444, 0, 0, 9);
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        chk("noc.front_sel", 32'(bus.front_sel), 32'd0);
        chk("noc.wr_ready", 32'(bus.wr_ready), 32'd1);
        rd(3);
        chk_rd("noc.rd3", 'h333, 1, 1, 7);

        // Commit, swap and write together: write lands in the bank that becomes front.
        bus.wr_en = 1'b1; bus.wr_column = COL_W'(300); bus.wr_vdist = VDIST_W'('h555);
        bus.wr_wtid = 2'd1; bus.wr_side = 1'b1; bus.wr_tex = 6'h2a;
        bus.wr_commit = 1'b1; bus.swap = 1'b1;
        step();
        idle();
        chk("cs.front_sel", 32'(bus.front_sel), 32'd1);
        chk("cs.wr_ready", 32'(bus.wr_ready), 32'd1);
        step();
        chk("cs.wr_ready_after", 32'(bus.wr_ready), 32'd1);
        rd(300);
        chk_rd("cs.rd300", 'h555, 1, 1, 'h2a);
        rd(3);
        chk_rd("cs.rd3", 'h444, 0, 0, 9);
        rd(700);
        chk_rd("oor.rd700", 0, 0, 0, 0);

        // Reset while pending, with live read data on the outputs.
        rd(300);
        bus.wr_commit = 1'b1; step(); bus.wr_commit = 1'b0;
        chk("prerst.wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("prerst.rd_vdist", 32'(bus.rd_vdist), 32'h555);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        chk("postrst.swap.front_valid", 32'(bus.front_valid), 32'd0);
        chk("postrst.swap.front_sel", 32'(bus.front_sel), 32'd0);
        rd(300);
        chk_rd("postrst.rd300", 0, 0, 0, 0);
        wr(640, 'h1234, 1, 1, 1);
        chk("oor.wr640.err", 32'(bus.err), 32'd1);
        chk("oor.wr640.wr_ready", 32'(bus.wr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
